// File: rtl/crc32_stream.sv
// crc32_stream: framed byte-stream CRC-32 engine (reflected poly 0xEDB88320).
// Ports: clk, rst_n (async, active low), clear (sync abort),
//   in_data/in_valid/in_first/in_last -> in_ready (byte stream in),
//   res_crc/res_ok/res_len/res_valid <- res_ready (one result per frame).
module crc32_stream #(
   parameter logic [31:0] INIT    = 32'hFFFFFFFF,
   parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
   parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
   parameter int          LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             in_last,
   output logic             in_ready,
   output logic [31:0]      res_crc,
   output logic             res_ok,
   output logic [LEN_W-1:0] res_len,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam logic [31:0] POLY = 32'hEDB88320;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [31:0]      crc;
   logic [LEN_W-1:0] count;

   logic             accept;
   logic             seed;
   logic [31:0]      crc_in;
   logic [31:0]      crc_out;
   logic [LEN_W-1:0] count_nxt;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      return r;
   endfunction

   // DONE blocks input so bytes never merge across frames.
   assign in_ready = (state != DONE);
   assign accept   = in_valid & in_ready;

   // A first byte mid-frame restarts: partial frame is discarded.
   assign seed    = (state == IDLE) | in_first;
   assign crc_in  = seed ? INIT : crc;
   assign crc_out = crc_byte(crc_in, in_data);

   assign count_nxt = seed ? LEN_W'(1) :
                      (&count) ? count :
                      count + LEN_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE, RUN: begin
               if (accept)
                  state_nxt = in_last ? DONE : RUN;
            end
            DONE: begin
               if (res_valid & res_ready)
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc       <= INIT;
         count     <= '0;
         res_crc   <= '0;
         res_ok    <= 1'b0;
         res_len   <= '0;
         res_valid <= 1'b0;
      end else if (clear) begin
         crc       <= INIT;
         count     <= '0;
         res_valid <= 1'b0;
      end else begin
         if (res_valid & res_ready)
            res_valid <= 1'b0;
         if (accept) begin
            count <= count_nxt;
            if (in_last) begin
               crc       <= INIT;
               res_crc   <= crc_out ^ XOROUT;
               res_ok    <= (crc_out == RESIDUE);
               res_len   <= count_nxt;
               res_valid <= 1'b1;
            end else begin
               crc <= crc_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: scoreboard bench for crc32_stream.
// Ports: drives clk/rst_n/clear/in_*/res_ready, checks res_* and in_ready.
module tb_crc32_stream;

   localparam int LW = 5;

   typedef struct {
      logic [31:0]   crc;
      logic          ok;
      logic [LW-1:0] len;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_first;
   logic          in_last;
   logic          in_ready;
   logic [31:0]   res_crc;
   logic          res_ok;
   logic [LW-1:0] res_len;
   logic          res_valid;
   logic          res_ready;

   int            checks = 0;
   int            errors = 0;
   res_t          sb[$];
   res_t          e;
   logic [31:0]   tbl[256];

   always #5 clk = ~clk;

   crc32_stream #(.LEN_W(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .res_crc   (res_crc),
      .res_ok    (res_ok),
      .res_len   (res_len),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(
      input logic [31:0]   c,
      input logic          ok,
      input logic [LW-1:0] len
   );
      res_t r;
      r.crc = c;
      r.ok  = ok;
      r.len = len;
      sb.push_back(r);
   endtask

   // Table-driven reference: returns the raw register after the bytes.
   function automatic logic [31:0] model_reg(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i])
         c = (c >> 8) ^ tbl[(c[7:0] ^ q[i])];
      return c;
   endfunction

   task automatic push_model(input logic [7:0] q[$]);
      logic [31:0] r;
      int          n;
      r = model_reg(q);
      n = q.size();
      push(r ^ 32'hFFFFFFFF, r == 32'hDEBB20E3,
           (n > 31) ? LW'(31) : LW'(n));
   endtask

   task automatic send_byte(
      input logic [7:0] d,
      input logic       f,
      input logic       l
   );
      int n;
      n        = 0;
      in_data  = d;
      in_first = f;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100)
         check("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      if (l)
         check("latency_valid", 32'(res_valid), 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] q[$]);
      foreach (q[i])
         send_byte(q[i], i == 0, i == q.size() - 1);
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("res_crc", res_crc, e.crc);
            check("res_ok", 32'(res_ok), 32'(e.ok));
            check("res_len", 32'(res_len), 32'(e.len));
         end
      end
   end

   initial begin
      logic [7:0]  digits[$];
      logic [7:0]  q[$];
      logic [31:0] c;
      int          n;

      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         tbl[i] = c;
      end
      digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                 8'h36, 8'h37, 8'h38, 8'h39};

      rst_n     = 1'b0;
      clear     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      res_ready = 1'b1;
      #12;
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_crc", res_crc, 32'd0);
      check("rst_len", 32'(res_len), 32'd0);
      check("rst_ok", 32'(res_ok), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // check value
      push(32'hCBF43926, 1'b0, LW'(9));
      send_frame(digits);
      drain();

      // residue frame
      q = digits;
      q.push_back(8'h26);
      q.push_back(8'h39);
      q.push_back(8'hF4);
      q.push_back(8'hCB);
      push(32'h2144DF1C, 1'b1, LW'(13));
      send_frame(q);
      drain();

      // single byte
      push(32'hD202EF8D, 1'b0, LW'(1));
      send_byte(8'h00, 1'b1, 1'b1);
      drain();

      // result held under backpressure
      res_ready = 1'b0;
      push(32'hCBF43926, 1'b0, LW'(9));
      send_frame(digits);
      in_data  = 8'h55;
      in_first = 1'b1;
      in_last  = 1'b1;
      in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("hold_ready", 32'(in_ready), 32'd0);
         check("hold_valid", 32'(res_valid), 32'd1);
         check("hold_crc", res_crc, 32'hCBF43926);
         check("hold_len", 32'(res_len), 32'd9);
      end
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      res_ready = 1'b1;
      drain();
      push(32'hCBF43926, 1'b0, LW'(9));
      send_frame(digits);
      drain();

      // restart on first mid-frame
      push(32'hCBF43926, 1'b0, LW'(9));
      send_byte(8'h41, 1'b1, 1'b0);
      send_byte(8'h42, 1'b0, 1'b0);
      send_frame(digits);
      drain();

      // clear mid-frame
      for (int i = 0; i < 4; i++)
         send_byte(digits[i], i == 0, 1'b0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clr_valid", 32'(res_valid), 32'd0);
      check("clr_ready", 32'(in_ready), 32'd1);
      push(32'hCBF43926, 1'b0, LW'(9));
      send_frame(digits);
      drain();

      // reset pulse mid-frame
      for (int i = 0; i < 4; i++)
         send_byte(digits[i], i == 0, 1'b0);
      rst_n = 1'b0;
      #2;
      check("rp_valid", 32'(res_valid), 32'd0);
      check("rp_ready", 32'(in_ready), 32'd1);
      check("rp_crc", res_crc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(32'hCBF43926, 1'b0, LW'(9));
      send_frame(digits);
      drain();

      // length saturation
      q.delete();
      for (int i = 0; i < 40; i++)
         q.push_back(8'(i * 7 + 3));
      push_model(q);
      send_frame(q);
      drain();

      // random frames, half with their own CRC appended
      for (int f = 0; f < 8; f++) begin
         q.delete();
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++)
            q.push_back(8'($urandom_range(0, 255)));
         if (f[0]) begin
            c = model_reg(q) ^ 32'hFFFFFFFF;
            q.push_back(c[7:0]);
            q.push_back(c[15:8]);
            q.push_back(c[23:16]);
            q.push_back(c[31:24]);
         end
         push_model(q);
         send_frame(q);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
